issue_ctrl: RTL

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_if.sv | 62 ++++++
 rtl/issue_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : issue_ctrl_if
// Purpose  : Bundles the decode-pair, pipeline-control and issue-result
//            signals exchanged between the decode stage and issue_ctrl.
// Modports : master - decode/pipeline side (drives pair and control inputs,
//                     observes issue results)
//            slave  - issue_ctrl side
// Signals  : flush/excp_flush/ertn_flush  kill requests
//            ex_stall                     EX cannot accept this cycle
//            id0_* / id1_*                older / younger decode slot
//            mdu_done                     MDU result ready pulse
//            issue0/issue1/id_stall       issue decisions (combinational)
//            state_o                      0 RUN, 1 SPLIT, 2 MDU_WAIT
// Revision : 1.0 - initial release
// ============================================================================
interface issue_ctrl_if;
  logic        flush;
  logic        excp_flush;
  logic        ertn_flush;
  logic        ex_stall;
  logic        id0_valid;
  logic        id1_valid;
  logic [31:0] id0_pc;
  logic [31:0] id1_pc;
  logic [4:0]  id0_reg1_addr;
  logic [4:0]  id0_reg2_addr;
  logic [4:0]  id1_reg1_addr;
  logic [4:0]  id1_reg2_addr;
  logic [4:0]  id0_wd;
  logic [4:0]  id1_wd;
  logic        id0_wreg;
  logic        id1_wreg;
  logic        id0_is_load;
  logic        id1_is_load;
  logic        id0_is_mdu;
  logic        id1_is_mdu;
  logic        mdu_done;
  logic        issue0;
  logic        issue1;
  logic        id_stall;
  logic [1:0]  state_o;

  modport master (
    output flush, excp_flush, ertn_flush, ex_stall,
    output id0_valid, id1_valid, id0_pc, id1_pc,
    output id0_reg1_addr, id0_reg2_addr, id1_reg1_addr, id1_reg2_addr,
    output id0_wd, id1_wd, id0_wreg, id1_wreg,
    output id0_is_load, id1_is_load, id0_is_mdu, id1_is_mdu, mdu_done,
    input  issue0, issue1, id_stall, state_o
  );

  modport slave (
    input  flush, excp_flush, ertn_flush, ex_stall,
    input  id0_valid, id1_valid, id0_pc, id1_pc,
    input  id0_reg1_addr, id0_reg2_addr, id1_reg1_addr, id1_reg2_addr,
    input  id0_wd, id1_wd, id0_wreg, id1_wreg,
    input  id0_is_load, id1_is_load, id0_is_mdu, id1_is_mdu, mdu_done,
    output issue0, issue1, id_stall, state_o
  );
endinterface
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : issue_ctrl
// Purpose  : Dual-issue control for a two-slot decode stage. Decides each
//            cycle which of the older (slot 0) and younger (slot 1)
//            instructions enter ID/EX, splitting dependent pairs, inserting a
//            load-use bubble and parking the pipe while the MDU is busy.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - issue_ctrl_if.slave (pair, kill/stall inputs, issue
//                   decisions and state_o)
// Revision : 1.0 - initial release
// ============================================================================
module issue_ctrl (
  input  wire         clk,
  input  wire         rst,
  issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SPLIT    = 2'd1,
    ST_MDU_WAIT = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       pending_q, pending_d;   // slot 1 still owed after an MDU wait
  logic       lu_valid_q, lu_valid_d;
  logic [4:0] lu_wd_q, lu_wd_d;

  logic kill;
  logic blocked0, blocked1;
  logic pc_seq, raw_dep, pair_conflict;
  logic split_req, mdu_issue, ld0_track, ld1_track;
  logic issue0, issue1, id_stall;

  // Hazard terms. lu_wd is never 0 while lu_valid, but r0 sources are still
  // excluded explicitly so the rule does not depend on that invariant.
  always_comb begin
    kill     = bus.flush | bus.excp_flush | bus.ertn_flush;
    blocked0 = lu_valid_q &&
               ((bus.id0_reg1_addr != 5'd0 && bus.id0_reg1_addr == lu_wd_q) ||
                (bus.id0_reg2_addr != 5'd0 && bus.id0_reg2_addr == lu_wd_q));
    blocked1 = lu_valid_q &&
               ((bus.id1_reg1_addr != 5'd0 && bus.id1_reg1_addr == lu_wd_q) ||
                (bus.id1_reg2_addr != 5'd0 && bus.id1_reg2_addr == lu_wd_q));
    // Only a truly sequential pair is checked for intra-pair conflicts.
    pc_seq   = (bus.id1_pc == bus.id0_pc + 32'd4);
    raw_dep  = bus.id0_wreg && (bus.id0_wd != 5'd0) &&
               ((bus.id0_wd == bus.id1_reg1_addr) ||
                (bus.id0_wd == bus.id1_reg2_addr));
    pair_conflict = pc_seq && (raw_dep ||
                               (bus.id0_is_mdu && bus.id1_is_mdu) ||
                               (bus.id0_is_load && bus.id1_is_load));
  end

  always_comb begin
    issue0     = 1'b0;
    issue1     = 1'b0;
    id_stall   = 1'b0;
    split_req  = 1'b0;
    mdu_issue  = 1'b0;
    ld0_track  = 1'b0;
    ld1_track  = 1'b0;
    state_d    = state_q;
    pending_d  = pending_q;
    lu_valid_d = lu_valid_q;
    lu_wd_d    = lu_wd_q;

    if (rst || kill) begin
      // Reset and kill both abort whatever is in flight, including a
      // half-issued pair or an MDU wait.
      state_d    = ST_RUN;
      pending_d  = 1'b0;
      lu_valid_d = 1'b0;
      lu_wd_d    = 5'd0;
    end else if (state_q == ST_ILLEGAL) begin
      // Recover even when EX is stalled; nothing issues on the way back.
      id_stall   = bus.id0_valid | bus.id1_valid;
      state_d    = ST_RUN;
      pending_d  = 1'b0;
    end else if (bus.ex_stall) begin
      id_stall   = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          issue0    = bus.id0_valid & ~blocked0;
          issue1    = issue0 & bus.id1_valid & ~blocked1 &
                      ~pair_conflict & ~bus.id0_is_mdu;
          split_req = issue0 & bus.id1_valid & ~issue1;
          id_stall  = (bus.id0_valid & ~issue0) | (bus.id1_valid & ~issue1);
          if (split_req) state_d = ST_SPLIT;
        end
        ST_SPLIT: begin
          issue1   = bus.id1_valid & ~blocked1;
          id_stall = bus.id1_valid & ~issue1;
          // If decode dropped slot 1 there is nothing left to finish.
          if (issue1 || !bus.id1_valid) state_d = ST_RUN;
        end
        ST_MDU_WAIT: begin
          id_stall = 1'b1;
          if (bus.mdu_done) begin
            state_d   = pending_q ? ST_SPLIT : ST_RUN;
            pending_d = 1'b0;
          end
        end
        default: state_d = ST_RUN;
      endcase

      // An issued MDU op parks the pipe; remember whether slot 1 is owed.
      mdu_issue = (issue0 & bus.id0_is_mdu) | (issue1 & bus.id1_is_mdu);
      if (mdu_issue) begin
        state_d   = ST_MDU_WAIT;
        pending_d = split_req;
      end

      // Scoreboard tracks only the load issued this edge; the younger slot
      // wins if both slots happen to issue loads.
      ld0_track  = issue0 & bus.id0_is_load & bus.id0_wreg & (bus.id0_wd != 5'd0);
      ld1_track  = issue1 & bus.id1_is_load & bus.id1_wreg & (bus.id1_wd != 5'd0);
      lu_valid_d = ld0_track | ld1_track;
      lu_wd_d    = ld1_track ? bus.id1_wd : (ld0_track ? bus.id0_wd : 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pending_q  <= 1'b0;
      lu_valid_q <= 1'b0;
      lu_wd_q    <= 5'd0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      lu_valid_q <= lu_valid_d;
      lu_wd_q    <= lu_wd_d;
    end
  end

  assign bus.issue0   = issue0;
  assign bus.issue1   = issue1;
  assign bus.id_stall = id_stall;
  assign bus.state_o  = state_q;

endmodule
`default_nettype wire
